// File: rtl/alien_edge_hit_detector.sv
// alien_edge_hit_detector: raises a one-cycle collision pulse and a 4-bit
// edge code when the alien layer and the border layer draw the same pixel.
// At most one pulse is issued per frame, and it lands on the edge band
// of the matrix bounding box.
//
// Ports:
//   clk, resetN          clock, async active-low reset
//   startOfFrame         one-cycle frame-start pulse
//   playGame             game running; low disarms detection
//   pixelX, pixelY       scan position (unsigned, 11 bit)
//   topLeftX, topLeftY   matrix top-left corner (signed, 11 bit)
//   alienDrawingRequest  alien layer draws this pixel
//   borderDrawingRequest border layer draws this pixel
//   collision            one-cycle hit pulse, one cycle after the pixel
//   HitEdgeCode          {left, top, right, bottom} of the accepted hit
//   alienReachedBottom   (ALIEN_BOTTOM_FLAG_EN only) sticky flag that is
//                        set by a hit on the bottom edge alone
//
// Optional feature macro: ALIEN_BOTTOM_FLAG_EN

module alien_edge_hit_detector #(
  parameter int OBJECT_W    = 512,
  parameter int OBJECT_H    = 128,
  parameter int EDGE_MARGIN = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        playGame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        alienDrawingRequest,
  input  logic        borderDrawingRequest,
  output logic        collision,
  output logic [3:0]  HitEdgeCode
`ifdef ALIEN_BOTTOM_FLAG_EN
  ,
  output logic        alienReachedBottom
`endif
);

  localparam logic signed [11:0] BOX_W =
    12'(OBJECT_W);
  localparam logic signed [11:0] BOX_H =
    12'(OBJECT_H);
  localparam logic signed [11:0] MARGIN =
    12'(EDGE_MARGIN);
  localparam logic signed [11:0] RIGHT_LO =
    12'(OBJECT_W - EDGE_MARGIN);
  localparam logic signed [11:0] BOTTOM_LO =
    12'(OBJECT_H - EDGE_MARGIN);

  typedef struct packed {
    logic left;
    logic top;
    logic right;
    logic bottom;
  } side_t;

  typedef enum logic [1:0] {
    DISARMED,
    ARMED,
    LOCKED
  } state_t;

  state_t state;

  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic               in_x;
  logic               in_y;
  logic               in_box;
  side_t              side;
  logic               overlap;
  logic               hit;
  logic               accept;

  // Pixel is zero-extended and corner is sign-extended, so a box that
  // hangs off the left or top of the screen still yields correct offsets.
  assign dx = $signed({1'b0, pixelX})
            - $signed({topLeftX[10], topLeftX});
  assign dy = $signed({1'b0, pixelY})
            - $signed({topLeftY[10], topLeftY});

  assign in_x   = !dx[11] && (dx < BOX_W);
  assign in_y   = !dy[11] && (dy < BOX_H);
  assign in_box = in_x && in_y;

  assign side.left   = dx < MARGIN;
  assign side.top    = dy < MARGIN;
  assign side.right  = dx >= RIGHT_LO;
  assign side.bottom = dy >= BOTTOM_LO;

  assign overlap = alienDrawingRequest
                && borderDrawingRequest
                && in_box
                && playGame;

  // Overlaps that touch no edge band are interior hits and are dropped.
  assign hit = overlap && (|side);

  // A startOfFrame in LOCKED re-arms first, so a hit in that same cycle
  // opens the new frame. In DISARMED the same pair only arms.
  always_comb begin
    accept = 1'b0;
    unique case (state)
      ARMED:   accept = hit;
      LOCKED:  accept = hit && startOfFrame;
      default: accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= DISARMED;
      collision   <= 1'b0;
      HitEdgeCode <= 4'b0000;
`ifdef ALIEN_BOTTOM_FLAG_EN
      alienReachedBottom <= 1'b0;
`endif
    end else if (!playGame) begin
      // The edge code is kept so the mover still sees the last hit.
      state     <= DISARMED;
      collision <= 1'b0;
`ifdef ALIEN_BOTTOM_FLAG_EN
      alienReachedBottom <= 1'b0;
`endif
    end else begin
      collision <= accept;
      if (accept) begin
        HitEdgeCode <= side;
      end
`ifdef ALIEN_BOTTOM_FLAG_EN
      if (accept && side.bottom
          && !side.left && !side.right) begin
        alienReachedBottom <= 1'b1;
      end
`endif
      unique case (state)
        DISARMED: begin
          if (startOfFrame) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (accept) begin
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (startOfFrame && !accept) begin
            state <= ARMED;
          end
        end
        default: state <= DISARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_alien_edge_hit_detector.sv
// Bench for alien_edge_hit_detector: directed steps, then random
// traffic near the box edges, checked against a frame-level model.

module tb_alien_edge_hit_detector;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        playGame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        alienDrawingRequest;
  logic        borderDrawingRequest;
  logic        collision;
  logic [3:0]  HitEdgeCode;
`ifdef ALIEN_BOTTOM_FLAG_EN
  logic        alienReachedBottom;
`endif

  int total = 0;
  int bad   = 0;

  // Model: enabled = a frame start was seen while playing,
  // got_hit = this frame already produced its pulse.
  bit         m_en;
  bit         m_got;
  bit         m_flag;
  logic [3:0] m_code;

  always #5 clk = ~clk;

  alien_edge_hit_detector dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (startOfFrame),
    .playGame             (playGame),
    .pixelX               (pixelX),
    .pixelY               (pixelY),
    .topLeftX             (topLeftX),
    .topLeftY             (topLeftY),
    .alienDrawingRequest  (alienDrawingRequest),
    .borderDrawingRequest (borderDrawingRequest),
    .collision            (collision),
`ifdef ALIEN_BOTTOM_FLAG_EN
    .alienReachedBottom   (alienReachedBottom),
`endif
    .HitEdgeCode          (HitEdgeCode)
  );

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en   = 1'b0;
    m_got  = 1'b0;
    m_flag = 1'b0;
    m_code = 4'b0000;
  endtask

  // One pixel cycle: drive inputs, predict, clock, compare.
  task automatic cyc(input bit sof, input bit pg,
                     input int px, input int py,
                     input int tx, input int ty,
                     input bit ar, input bit br);
    int         dx;
    int         dy;
    bit         inb;
    bit         ov;
    bit         acc;
    logic [3:0] e;
    startOfFrame         = sof;
    playGame             = pg;
    pixelX               = 11'(px);
    pixelY               = 11'(py);
    topLeftX             = 11'(tx);
    topLeftY             = 11'(ty);
    alienDrawingRequest  = ar;
    borderDrawingRequest = br;
    dx  = px - tx;
    dy  = py - ty;
    inb = dx >= 0 && dx < 512 && dy >= 0 && dy < 128;
    e   = {dx < 4, dy < 4, dx >= 508, dy >= 124};
    ov  = ar && br && pg && inb && (e != 4'b0000);
    acc = m_en && (!m_got || sof) && ov;
    if (acc) begin
      m_code = e;
      if (e == 4'b0001) m_flag = 1'b1;
    end
    if (!pg) begin
      m_en   = 1'b0;
      m_flag = 1'b0;
    end else if (!m_en) begin
      if (sof) begin
        m_en  = 1'b1;
        m_got = 1'b0;
      end
    end else if (acc) begin
      m_got = 1'b1;
    end else if (sof) begin
      m_got = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("collision", {3'b000, collision}, {3'b000, acc});
    chk("code", HitEdgeCode, m_code);
`ifdef ALIEN_BOTTOM_FLAG_EN
    chk("flag", {3'b000, alienReachedBottom}, {3'b000, m_flag});
`endif
  endtask

  initial begin
    int tx;
    int ty;
    int px;
    int py;
    resetN               = 1'b0;
    startOfFrame         = 1'b0;
    playGame             = 1'b0;
    pixelX               = '0;
    pixelY               = '0;
    topLeftX             = '0;
    topLeftY             = '0;
    alienDrawingRequest  = 1'b0;
    borderDrawingRequest = 1'b0;
    model_reset();
    #12;
    chk("rst_col", {3'b000, collision}, 4'b0000);
    chk("rst_code", HitEdgeCode, 4'b0000);
    @(posedge clk);
    #1;
    resetN = 1'b1;

    // left hit
    cyc(1, 1, 0, 0, 32, 64, 0, 0);
    cyc(0, 1, 33, 100, 32, 64, 1, 1);
    cyc(0, 1, 0, 0, 32, 64, 0, 0);
    // top-right corner, single pulse
    cyc(1, 1, 0, 0, 32, 64, 0, 0);
    cyc(0, 1, 543, 66, 32, 64, 1, 1);
    cyc(0, 1, 543, 66, 32, 64, 1, 1);
    // one per frame
    cyc(1, 1, 0, 0, 32, 64, 0, 0);
    cyc(0, 1, 33, 100, 32, 64, 1, 1);
    cyc(0, 1, 543, 150, 32, 64, 1, 1);
    cyc(1, 1, 0, 0, 32, 64, 0, 0);
    cyc(0, 1, 543, 150, 32, 64, 1, 1);
    // interior and request gating
    cyc(1, 1, 0, 0, 32, 64, 0, 0);
    cyc(0, 1, 200, 120, 32, 64, 1, 1);
    cyc(0, 1, 33, 100, 32, 64, 1, 0);
    cyc(0, 1, 33, 100, 32, 64, 1, 1);
    // disarm and re-arm
    cyc(1, 1, 0, 0, 32, 64, 0, 0);
    cyc(0, 0, 33, 100, 32, 64, 1, 1);
    cyc(0, 1, 33, 100, 32, 64, 1, 1);
    cyc(1, 1, 33, 100, 32, 64, 1, 1);
    cyc(0, 1, 543, 150, 32, 64, 1, 1);
    // frame start and hit together while locked
    cyc(1, 1, 33, 100, 32, 64, 1, 1);
    // negative corner, bottom edge
    cyc(1, 1, 0, 0, -10, 64, 0, 0);
    cyc(0, 1, 0, 190, -10, 64, 1, 1);
    cyc(0, 1, 0, 0, -10, 64, 0, 0);

    // reset during a pulse
    cyc(1, 1, 0, 0, 32, 64, 0, 0);
    cyc(0, 1, 33, 100, 32, 64, 1, 1);
    resetN = 1'b0;
    #1;
    chk("midrst_col", {3'b000, collision}, 4'b0000);
    chk("midrst_code", HitEdgeCode, 4'b0000);
`ifdef ALIEN_BOTTOM_FLAG_EN
    chk("midrst_flag", {3'b000, alienReachedBottom}, 4'b0000);
`endif
    model_reset();
    @(posedge clk);
    #1;
    resetN = 1'b1;

    for (int i = 0; i < 600; i++) begin
      tx = int'($urandom_range(0, 700)) - 40;
      ty = int'($urandom_range(0, 300)) - 20;
      case ($urandom_range(0, 2))
        0:       px = tx + int'($urandom_range(0, 6)) - 2;
        1:       px = tx + int'($urandom_range(505, 514));
        default: px = tx + int'($urandom_range(0, 530)) - 10;
      endcase
      case ($urandom_range(0, 2))
        0:       py = ty + int'($urandom_range(0, 6)) - 2;
        1:       py = ty + int'($urandom_range(121, 130));
        default: py = ty + int'($urandom_range(0, 150)) - 10;
      endcase
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      cyc($urandom_range(0, 7) == 0,
          $urandom_range(0, 24) != 0,
          px, py, tx, ty,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
